pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 20 ++
 rtl/pc_sequencer_if.sv | 48 ++++
 rtl/pc_sequencer_ret_stack.sv | 65 ++++++
 rtl/pc_sequencer.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the pc_sequencer slice.
// State encoding, default widths and the stack-pointer width helper.
package pc_seq_pack;

   localparam int AW_DEF    = 10;
   localparam int DEPTH_DEF = 4;
   localparam int NSUB_DEF  = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_e;

   // sp must be able to hold DEPTH itself (the "full" value)
   function automatic int sp_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundles for the sequencer: decoded-control bundle and the
// return-stack port between pc_sequencer and ret_stack.
interface pc_seq_ctrl_if #(
   parameter int AW = pc_seq_pack::AW_DEF
);
   logic          br_take;
   logic [AW-1:0] br_target;
   logic          skip_take;
   logic [2:0]    skip_n;
   logic          call;
   logic [3:0]    sub_idx;
   logic          ret;
   logic          halt;

   modport master (
      output br_take, br_target, skip_take, skip_n,
      output call, sub_idx, ret, halt
   );
   modport slave (
      input br_take, br_target, skip_take, skip_n,
      input call, sub_idx, ret, halt
   );
endinterface

interface ret_stack_if #(
   parameter int AW    = pc_seq_pack::AW_DEF,
   parameter int DEPTH = pc_seq_pack::DEPTH_DEF
);
   localparam int SPW = pc_seq_pack::sp_w(DEPTH);

   logic           push;
   logic           pop;
   logic           clr;
   logic [AW-1:0]  push_data;
   logic [AW-1:0]  top;
   logic [SPW-1:0] sp;
   logic           full;
   logic           empty;

   modport master (
      output push, pop, clr, push_data,
      input  top, sp, full, empty
   );
   modport slave (
      input  push, pop, clr, push_data,
      output top, sp, full, empty
   );
endinterface

// File: rtl/pc_sequencer_ret_stack.sv
// Return-address stack: push/pop/clear with top, sp, full, empty.
// WRAP=1 lets sp wrap modulo DEPTH; WRAP=0 lets sp reach DEPTH.
module ret_stack
   import pc_seq_pack::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter bit WRAP  = 1'b1
) (
   input  logic         clk,
   input  logic         reset,
   ret_stack_if.slave   st
);

   localparam int SPW = sp_w(DEPTH);
   localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [AW-1:0]  mem_q [DEPTH];
   logic [SPW-1:0] sp_q;
   logic [SPW-1:0] sp_d;
   logic [IW-1:0]  wr_idx;
   logic [IW-1:0]  rd_idx;

   always_comb begin
      wr_idx = IW'(sp_q);
      rd_idx = (sp_q == '0) ? IW'(DEPTH - 1)
                            : IW'(sp_q - SPW'(1));
   end

   always_comb begin
      sp_d = sp_q;
      if (st.clr) begin
         sp_d = '0;
      end else if (st.push) begin
         if (WRAP && sp_q == SPW'(DEPTH - 1))
            sp_d = '0;
         else
            sp_d = sp_q + SPW'(1);
      end else if (st.pop) begin
         if (sp_q == '0)
            sp_d = SPW'(DEPTH - 1);
         else
            sp_d = sp_q - SPW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         sp_q <= '0;
      else
         sp_q <= sp_d;
   end

   // contents are don't-care after reset; only sp is cleared
   always_ff @(posedge clk) begin
      if (st.push && !st.clr)
         mem_q[wr_idx] <= st.push_data;
   end

   assign st.top   = mem_q[rd_idx];
   assign st.sp    = sp_q;
   assign st.full  = (sp_q == SPW'(DEPTH));
   assign st.empty = (sp_q == '0);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: IDLE/RUN/HALT with branch, skip, call, ret.
// Define PC_SEQ_STACK_CHECK_EN to trap stack over/underflow into err.
module pc_sequencer
   import pc_seq_pack::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int NSUB  = NSUB_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          cfg_we,
   input  logic [3:0]    cfg_idx,
   input  logic [AW-1:0] cfg_addr,
   input  logic          br_take,
   input  logic [AW-1:0] br_target,
   input  logic          skip_take,
   input  logic [2:0]    skip_n,
   input  logic          call,
   input  logic [3:0]    sub_idx,
   input  logic          ret,
   input  logic          halt,
   output logic [AW-1:0] pc,
   output logic          busy,
   output logic          done,
   output logic          err
);

`ifdef PC_SEQ_STACK_CHECK_EN
   localparam bit CHECK = 1'b1;
`else
   localparam bit CHECK = 1'b0;
`endif

   state_e        state_q, state_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          err_q, err_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [AW-1:0] vec_q [NSUB];
   logic          vec_we;
   logic [AW-1:0] pc_inc;
   logic [AW-1:0] call_tgt;

   ret_stack_if #(.AW(AW), .DEPTH(DEPTH)) st_if ();

   ret_stack #(
      .AW    (AW),
      .DEPTH (DEPTH),
      .WRAP  (!CHECK)
   ) u_ret_stack (
      .clk   (clk),
      .reset (reset),
      .st    (st_if)
   );

   assign vec_we = cfg_we && (state_q != ST_RUN)
                && (int'(cfg_idx) < NSUB);

   always_comb begin
      pc_inc   = pc_q + AW'(1);
      call_tgt = (int'(sub_idx) < NSUB) ? vec_q[sub_idx] : '0;
   end

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      err_d           = err_q;
      st_if.push      = 1'b0;
      st_if.pop       = 1'b0;
      st_if.clr       = 1'b0;
      st_if.push_data = pc_inc;
      unique case (state_q)
         ST_IDLE, ST_HALT: begin
            if (start) begin
               state_d   = ST_RUN;
               pc_d      = '0;
               st_if.clr = 1'b1;
            end
         end
         ST_RUN: begin
            if (halt) begin
               state_d = ST_HALT;
            end else if (ret) begin
               if (CHECK && st_if.empty) begin
                  err_d   = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  pc_d      = st_if.top;
                  st_if.pop = 1'b1;
               end
            end else if (call) begin
               if (CHECK && st_if.full) begin
                  err_d   = 1'b1;
                  state_d = ST_HALT;
               end else begin
                  pc_d       = call_tgt;
                  st_if.push = 1'b1;
               end
            end else if (skip_take) begin
               pc_d = pc_inc + AW'(skip_n);
            end else if (br_take) begin
               pc_d = br_target;
            end else begin
               pc_d = pc_inc;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d == ST_RUN);
      done_d = (state_d == ST_HALT);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         pc_q    <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         for (int i = 0; i < NSUB; i++)
            vec_q[i] <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         if (vec_we)
            vec_q[cfg_idx] <= cfg_addr;
      end
   end

   assign pc   = pc_q;
   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;

endmodule
